// File: rtl/time_pkg.sv
// -----------------------------------------------------------------------------
// time_pkg
// Shared types and constants for the clock time-set controller.
//   ctrl_state_t : controller state (RUN plus one SET state per digit)
//   *_MAX        : highest legal value of each digit (24-hour format)
//   SEL_*        : edit_sel encodings, also used as set-strobe bit indices
//   clamp_hr_u   : entry value for the hour-units edit digit
// -----------------------------------------------------------------------------
package time_pkg;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    S_HRT  = 3'd1,
    S_HRU  = 3'd2,
    S_MINT = 3'd3,
    S_MINU = 3'd4
  } ctrl_state_t;

  localparam logic [3:0] HR_T_MAX    = 4'd2;
  localparam logic [3:0] HR_U_MAX    = 4'd9;
  localparam logic [3:0] HR_U_MAX_20 = 4'd3;
  localparam logic [3:0] MIN_T_MAX   = 4'd5;
  localparam logic [3:0] MIN_U_MAX   = 4'd9;

  localparam logic [1:0] SEL_HR_T  = 2'd0;
  localparam logic [1:0] SEL_HR_U  = 2'd1;
  localparam logic [1:0] SEL_MIN_T = 2'd2;
  localparam logic [1:0] SEL_MIN_U = 2'd3;

  // With hours in the twenties the units digit may not exceed 3, so the
  // stored value is pulled down on entry to keep the edit value legal.
  function automatic logic [3:0] clamp_hr_u(input logic [3:0] hr_u,
                                            input logic [3:0] hr_t);
    if ((hr_t == HR_T_MAX) && (hr_u > HR_U_MAX_20)) begin
      return HR_U_MAX_20;
    end
    return hr_u;
  endfunction

endpackage

// File: rtl/time_set_ctrl_digit_wrap_inc.sv
// -----------------------------------------------------------------------------
// digit_wrap_inc
// Combinational wrapping increment for one BCD-style digit.
//   val_i     in  4  current digit value
//   max_i     in  4  highest legal value of the digit
//   nxt_val_o out 4  val_i+1, or 0 once val_i has reached (or exceeds) max_i
// An out-of-range value (above max) also wraps to 0, so a corrupt register
// value recovers on the first increment.
// -----------------------------------------------------------------------------
module digit_wrap_inc (
  input  logic [3:0] val_i,
  input  logic [3:0] max_i,
  output logic [3:0] nxt_val_o
);

  always_comb begin
    nxt_val_o = 4'd0;
    if (val_i < max_i) begin
      nxt_val_o = val_i + 4'd1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Sequencing controller between the debounced buttons and the four clock digit
// registers (24-hour format). In RUN the minute tick is forwarded to the
// minute-units register; in SET the digits are edited in the order
// hr_t -> hr_u -> min_t -> min_u, each committed by a one-cycle set_* pulse.
//
// Ports:
//   clk, reset (async, active-high)
//   mode_pulse, up_pulse   single-cycle debounced buttons
//   tick_1min              minute tick, forwarded as inc_min_u in RUN only
//   tick_1s                second tick, used only by the SET timeout
//   min_u_q..hr_t_q [3:0]  current digit register values
//   inc_min_u              combinational increment to minute units
//   set_hr_t..set_min_u    registered load strobes (at most one high)
//   new_val [3:0]          value to load, 0 when no strobe is high
//   editing                high in any SET state
//   edit_sel [1:0]         0=hr_t 1=hr_u 2=min_t 3=min_u
//   edit_val [3:0]         digit currently being edited
//
// Build option: define TIME_SET_TIMEOUT_EN to abandon SET mode after
// TIMEOUT_SEC seconds without a button press (nothing is committed).
// -----------------------------------------------------------------------------
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int TIMEOUT_SEC = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_pulse,
  input  logic       up_pulse,
  input  logic       tick_1min,
  input  logic       tick_1s,
  input  logic [3:0] min_u_q,
  input  logic [3:0] min_t_q,
  input  logic [3:0] hr_u_q,
  input  logic [3:0] hr_t_q,
  output logic       inc_min_u,
  output logic       set_min_u,
  output logic       set_min_t,
  output logic       set_hr_u,
  output logic       set_hr_t,
  output logic [3:0] new_val,
  output logic       editing,
  output logic [1:0] edit_sel,
  output logic [3:0] edit_val
);

  ctrl_state_t state_q, state_d;
  logic [3:0]  edit_val_q, edit_val_d;
  logic [3:0]  hr_t_cmt_q, hr_t_cmt_d;   // hr_t value just committed
  logic [3:0]  set_vec_q, set_vec_d;     // bit index = SEL_* encoding
  logic [3:0]  new_val_q, new_val_d;
  logic        timeout_hit;

  logic [3:0]  nxt_hr_t, nxt_hr_u, nxt_min_t, nxt_min_u;
  logic [3:0]  hr_u_max;

  // The hr_t register itself only updates after the set_hr_t pulse, so the
  // hour-units limit is taken from the locally held committed value.
  assign hr_u_max = (hr_t_cmt_q == HR_T_MAX) ? HR_U_MAX_20 : HR_U_MAX;

  digit_wrap_inc u_inc_hr_t  (.val_i(edit_val_q), .max_i(HR_T_MAX),  .nxt_val_o(nxt_hr_t));
  digit_wrap_inc u_inc_hr_u  (.val_i(edit_val_q), .max_i(hr_u_max),  .nxt_val_o(nxt_hr_u));
  digit_wrap_inc u_inc_min_t (.val_i(edit_val_q), .max_i(MIN_T_MAX), .nxt_val_o(nxt_min_t));
  digit_wrap_inc u_inc_min_u (.val_i(edit_val_q), .max_i(MIN_U_MAX), .nxt_val_o(nxt_min_u));

`ifdef TIME_SET_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_SEC);

  logic [7:0] sec_cnt_q, sec_cnt_d;

  assign timeout_hit = (state_q != RUN) && (sec_cnt_q == TIMEOUT_CNT);

  // Held at zero in RUN, so it is already clear on entry to SET.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    if (state_q == RUN) begin
      sec_cnt_d = 8'd0;
    end else if (mode_pulse || up_pulse) begin
      sec_cnt_d = 8'd0;
    end else if (tick_1s && !timeout_hit) begin
      sec_cnt_d = sec_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_cnt_q <= 8'd0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = ^{tick_1s, 8'(TIMEOUT_SEC)};
`endif

  // Next-state / commit logic. A mode press in a SET state commits the
  // current edit value and preloads the next digit at the same edge; mode
  // takes priority over up when both arrive together.
  always_comb begin
    state_d    = state_q;
    edit_val_d = edit_val_q;
    hr_t_cmt_d = hr_t_cmt_q;
    set_vec_d  = 4'b0000;
    new_val_d  = 4'd0;

    if (timeout_hit) begin
      state_d    = RUN;
      edit_val_d = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (mode_pulse) begin
            state_d    = S_HRT;
            edit_val_d = hr_t_q;
          end
        end
        S_HRT: begin
          if (mode_pulse) begin
            set_vec_d[SEL_HR_T] = 1'b1;
            new_val_d           = edit_val_q;
            hr_t_cmt_d          = edit_val_q;
            state_d             = S_HRU;
            edit_val_d          = clamp_hr_u(hr_u_q, edit_val_q);
          end else if (up_pulse) begin
            edit_val_d = nxt_hr_t;
          end
        end
        S_HRU: begin
          if (mode_pulse) begin
            set_vec_d[SEL_HR_U] = 1'b1;
            new_val_d           = edit_val_q;
            state_d             = S_MINT;
            edit_val_d          = min_t_q;
          end else if (up_pulse) begin
            edit_val_d = nxt_hr_u;
          end
        end
        S_MINT: begin
          if (mode_pulse) begin
            set_vec_d[SEL_MIN_T] = 1'b1;
            new_val_d            = edit_val_q;
            state_d              = S_MINU;
            edit_val_d           = min_u_q;
          end else if (up_pulse) begin
            edit_val_d = nxt_min_t;
          end
        end
        S_MINU: begin
          if (mode_pulse) begin
            set_vec_d[SEL_MIN_U] = 1'b1;
            new_val_d            = edit_val_q;
            state_d              = RUN;
            edit_val_d           = 4'd0;
          end else if (up_pulse) begin
            edit_val_d = nxt_min_u;
          end
        end
        default: begin
          state_d    = RUN;
          edit_val_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      edit_val_q <= 4'd0;
      hr_t_cmt_q <= 4'd0;
      set_vec_q  <= 4'b0000;
      new_val_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      edit_val_q <= edit_val_d;
      hr_t_cmt_q <= hr_t_cmt_d;
      set_vec_q  <= set_vec_d;
      new_val_q  <= new_val_d;
    end
  end

  always_comb begin
    edit_sel = SEL_HR_T;
    case (state_q)
      S_HRU:   edit_sel = SEL_HR_U;
      S_MINT:  edit_sel = SEL_MIN_T;
      S_MINU:  edit_sel = SEL_MIN_U;
      default: edit_sel = SEL_HR_T;
    endcase
  end

  assign inc_min_u = tick_1min && (state_q == RUN);
  assign editing   = (state_q != RUN);
  assign edit_val  = edit_val_q;
  assign new_val   = new_val_q;
  assign set_hr_t  = set_vec_q[SEL_HR_T];
  assign set_hr_u  = set_vec_q[SEL_HR_U];
  assign set_min_t = set_vec_q[SEL_MIN_T];
  assign set_min_u = set_vec_q[SEL_MIN_U];

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed bench for time_set_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are observed there or one unit later. The observation
// vector packs {editing, edit_sel, edit_val, sets[min_u,min_t,hr_u,hr_t],
// new_val}. Built with TIMEOUT_SEC=3; the timeout scenario follows
// TIME_SET_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode_pulse = 1'b0;
  logic       up_pulse = 1'b0;
  logic       tick_1min = 1'b0;
  logic       tick_1s = 1'b0;
  logic [3:0] min_u_q = 4'd0;
  logic [3:0] min_t_q = 4'd0;
  logic [3:0] hr_u_q = 4'd0;
  logic [3:0] hr_t_q = 4'd0;
  logic       inc_min_u;
  logic       set_min_u, set_min_t, set_hr_u, set_hr_t;
  logic [3:0] new_val;
  logic       editing;
  logic [1:0] edit_sel;
  logic [3:0] edit_val;

  logic [3:0]  sets;
  logic [14:0] obs;
  int          total = 0;
  int          bad = 0;
  int          set_seen = 0;

  assign sets = {set_min_u, set_min_t, set_hr_u, set_hr_t};
  assign obs  = {editing, edit_sel, edit_val, sets, new_val};

  time_set_ctrl #(.TIMEOUT_SEC(3)) dut (
    .clk(clk), .reset(reset), .mode_pulse(mode_pulse), .up_pulse(up_pulse),
    .tick_1min(tick_1min), .tick_1s(tick_1s),
    .min_u_q(min_u_q), .min_t_q(min_t_q), .hr_u_q(hr_u_q), .hr_t_q(hr_t_q),
    .inc_min_u(inc_min_u),
    .set_min_u(set_min_u), .set_min_t(set_min_t),
    .set_hr_u(set_hr_u), .set_hr_t(set_hr_t),
    .new_val(new_val), .editing(editing), .edit_sel(edit_sel),
    .edit_val(edit_val)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sets != 4'b0000) set_seen = set_seen + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic u);
    mode_pulse = m;
    up_pulse   = u;
    step();
    mode_pulse = 1'b0;
    up_pulse   = 1'b0;
  endtask

  task automatic sec_tick();
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++;
    if (obs !== 15'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=%h", obs, 15'd0);
    end
    reset = 1'b0;
    step();
    total++;
    if ({obs, inc_min_u} !== 16'd0) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", {obs, inc_min_u}, 16'd0);
    end
  endtask

  task automatic test_run_ticks();
    for (int i = 0; i < 3; i++) begin
      tick_1min = 1'b1;
      #1;
      total++;
      if (inc_min_u !== 1'b1) begin
        bad++;
        $display("FAIL run_tick_%0d inc got=%b want=1", i, inc_min_u);
      end
      @(posedge clk);
      #1;
      tick_1min = 1'b0;
      #1;
      total++;
      if ({inc_min_u, sets} !== 5'b0) begin
        bad++;
        $display("FAIL run_gap_%0d got=%b want=%b", i, {inc_min_u, sets}, 5'b0);
      end
      step();
    end
  endtask

  task automatic test_set_sequence();
    logic [14:0] exp;
    hr_t_q = 4'd1; hr_u_q = 4'd7; min_t_q = 4'd4; min_u_q = 4'd2;
    press(1'b1, 1'b0);
    exp = {1'b1, 2'd0, 4'd1, 4'b0000, 4'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL seq_enter got=%h want=%h", obs, exp); end
    press(1'b0, 1'b1);
    exp = {1'b1, 2'd0, 4'd2, 4'b0000, 4'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL seq_up_hrt got=%h want=%h", obs, exp); end
    press(1'b1, 1'b0);
    exp = {1'b1, 2'd1, 4'd3, 4'b0001, 4'd2};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL seq_commit_hrt got=%h want=%h", obs, exp); end
    step();
    exp = {1'b1, 2'd1, 4'd3, 4'b0000, 4'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL seq_pulse_end got=%h want=%h", obs, exp); end
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
    exp = {1'b1, 2'd1, 4'd2, 4'b0000, 4'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL seq_hru_wrap got=%h want=%h", obs, exp); end
    press(1'b1, 1'b0);
    exp = {1'b1, 2'd2, 4'd4, 4'b0010, 4'd2};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL seq_commit_hru got=%h want=%h", obs, exp); end
    press(1'b1, 1'b0);
    exp = {1'b1, 2'd3, 4'd2, 4'b0100, 4'd4};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL seq_commit_mint got=%h want=%h", obs, exp); end
    press(1'b1, 1'b0);
    exp = {1'b0, 2'd0, 4'd0, 4'b1000, 4'd2};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL seq_commit_minu got=%h want=%h", obs, exp); end
    step();
    total++;
    if (obs !== 15'd0) begin bad++; $display("FAIL seq_back_run got=%h want=%h", obs, 15'd0); end
  endtask

  task automatic test_wrap_and_tick_drop();
    logic [14:0] exp;
    hr_t_q = 4'd0; hr_u_q = 4'd0; min_t_q = 4'd5; min_u_q = 4'd9;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    exp = {1'b1, 2'd2, 4'd5, 4'b0010, 4'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL wrap_enter_mint got=%h want=%h", obs, exp); end
    press(1'b0, 1'b1);
    exp = {1'b1, 2'd2, 4'd0, 4'b0000, 4'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL wrap_mint got=%h want=%h", obs, exp); end
    tick_1min = 1'b1;
    #1;
    total++;
    if (inc_min_u !== 1'b0) begin bad++; $display("FAIL tick_in_set inc got=%b want=0", inc_min_u); end
    tick_1min = 1'b0;
    press(1'b1, 1'b0);
    exp = {1'b1, 2'd3, 4'd9, 4'b0100, 4'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL wrap_enter_minu got=%h want=%h", obs, exp); end
    press(1'b0, 1'b1);
    exp = {1'b1, 2'd3, 4'd0, 4'b0000, 4'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL wrap_minu got=%h want=%h", obs, exp); end
    press(1'b1, 1'b0);
    exp = {1'b0, 2'd0, 4'd0, 4'b1000, 4'd0};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL wrap_exit got=%h want=%h", obs, exp); end
    step();
  endtask

  task automatic test_mode_up_same();
    logic [14:0] exp;
    hr_t_q = 4'd1; hr_u_q = 4'd5;
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    exp = {1'b1, 2'd1, 4'd5, 4'b0001, 4'd1};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL mode_up_same got=%h want=%h", obs, exp); end
  endtask

  task automatic test_reset_mid_set();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({obs, inc_min_u} !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid_async got=%h want=%h", {obs, inc_min_u}, 16'd0);
    end
    step();
    reset = 1'b0;
    step();
    tick_1min = 1'b1;
    #1;
    total++;
    if ({obs, inc_min_u} !== 16'd1) begin
      bad++;
      $display("FAIL reset_mid_run got=%h want=%h", {obs, inc_min_u}, 16'd1);
    end
    tick_1min = 1'b0;
    step();
  endtask

  task automatic test_out_of_range();
    hr_t_q = 4'd7;
    press(1'b1, 1'b0);
    total++;
    if (edit_val !== 4'd7) begin bad++; $display("FAIL oor_load got=%0d want=7", edit_val); end
    press(1'b0, 1'b1);
    total++;
    if (edit_val !== 4'd0) begin bad++; $display("FAIL oor_wrap got=%0d want=0", edit_val); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    hr_t_q = 4'd1;
    set_seen = 0;
    press(1'b1, 1'b0);
`ifdef TIME_SET_TIMEOUT_EN
    sec_tick();
    sec_tick();
    total++;
    if (editing !== 1'b1) begin bad++; $display("FAIL to_early got=%b want=1", editing); end
    sec_tick();
    total++;
    if ({editing, set_seen[3:0]} !== 5'b0) begin
      bad++;
      $display("FAIL to_expire editing=%b sets=%0d want 0/0", editing, set_seen);
    end
    press(1'b1, 1'b0);
    set_seen = 0;
    sec_tick();
    sec_tick();
    press(1'b0, 1'b1);
    sec_tick();
    sec_tick();
    total++;
    if (editing !== 1'b1) begin bad++; $display("FAIL to_restart got=%b want=1", editing); end
    sec_tick();
    total++;
    if ({editing, set_seen[3:0]} !== 5'b0) begin
      bad++;
      $display("FAIL to_restart_expire editing=%b sets=%0d want 0/0", editing, set_seen);
    end
`else
    for (int i = 0; i < 5; i++) sec_tick();
    total++;
    if ({editing, set_seen[3:0]} !== 5'b10000) begin
      bad++;
      $display("FAIL no_timeout editing=%b sets=%0d want 1/0", editing, set_seen);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_ticks();
    test_set_sequence();
    test_wrap_and_tick_drop();
    test_mode_up_same();
    test_reset_mid_set();
    test_out_of_range();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
